// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: shared FSM states, default servo timing constants and the pulse-width helper.
package servo_pwm_pkg;
  localparam int unsigned FRAME_20MS_TICKS = 1000000;
  localparam int unsigned PULSE_1MS_TICKS = 50000;
  localparam int unsigned STEP_DEF_TICKS = 195;
  typedef logic [7:0] pos_t;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int unsigned width_ticks(pos_t pos, int unsigned min_ticks, int unsigned step_ticks);
    return min_ticks + 32'(pos) * step_ticks;
  endfunction
endpackage

// File: rtl/servo_pwm_chan.sv
// servo_pwm_chan: one servo channel -- shadow/active position pair and pulse compare.
// With SERVO_PWM_SLEW_EN defined, each commit moves active toward shadow by at most SLEW_STEP.
module servo_pwm_chan
  import servo_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 20,
  parameter int unsigned MIN_TICKS = PULSE_1MS_TICKS,
  parameter int unsigned STEP_TICKS = STEP_DEF_TICKS,
  parameter int unsigned RESET_POS = 128
`ifdef SERVO_PWM_SLEW_EN
  , parameter int unsigned SLEW_STEP = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             commit,
  input  logic             wr_en,
  input  logic [7:0]       wr_pos,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);
  pos_t shadow, active, active_nxt;
  logic [CNT_W-1:0] width;
`ifdef SERVO_PWM_SLEW_EN
  localparam pos_t STEP = pos_t'(SLEW_STEP);
  assign active_nxt = (shadow > active) ? ((shadow - active > STEP) ? active + STEP : shadow)
                                        : ((active - shadow > STEP) ? active - STEP : shadow);
`else
  assign active_nxt = shadow;
`endif
  assign width = CNT_W'(width_ticks(active, MIN_TICKS, STEP_TICKS));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= pos_t'(RESET_POS);
      active <= pos_t'(RESET_POS);
      pwm    <= 1'b0;
    end else begin
      if (wr_en) shadow <= wr_pos;
      if (commit) active <= active_nxt;
      pwm <= run && (cnt < width);
    end
  end
endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel servo PWM generator sharing one frame counter.
// Optional SERVO_PWM_SLEW_EN rate-limits position changes per frame.
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = 2,
  parameter int unsigned PERIOD_TICKS = FRAME_20MS_TICKS,
  parameter int unsigned MIN_TICKS = PULSE_1MS_TICKS,
  parameter int unsigned STEP_TICKS = STEP_DEF_TICKS,
  parameter int unsigned CNT_W = 20,
  parameter int unsigned RESET_POS = 128,
  parameter int unsigned SLEW_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [CH_W-1:0] wr_chan,
  input  logic [7:0]      wr_pos,
  output logic [N_CH-1:0] pwm,
  output logic            frame_start,
  output logic            running
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic wrap, commit, wr_fire;
  assign wrap = cnt == CNT_W'(PERIOD_TICKS - 1);
  always_comb begin
    running   = state == RUN;
    commit    = running ? wrap : en;
    cnt_nxt   = (running && !wrap) ? cnt + CNT_W'(1) : '0;
    state_nxt = running ? ((wrap && !en) ? IDLE : RUN) : (en ? RUN : IDLE);
    // The widest legal pulse must end inside the frame, so pwm never sticks high.
    assert ((64'd1 << CNT_W) > 64'(PERIOD_TICKS) && MIN_TICKS + 255 * STEP_TICKS < PERIOD_TICKS
            && RESET_POS <= 255 && SLEW_STEP >= 1 && SLEW_STEP <= 255);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
  assign frame_start = running && cnt == '0;
  assign wr_ready    = !commit;
  assign wr_fire     = wr_valid && wr_ready;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_pwm_chan #(
      .CNT_W(CNT_W),
      .MIN_TICKS(MIN_TICKS),
      .STEP_TICKS(STEP_TICKS),
      .RESET_POS(RESET_POS)
`ifdef SERVO_PWM_SLEW_EN
      , .SLEW_STEP(SLEW_STEP)
`endif
    ) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .run(running),
      .commit(commit),
      .wr_en(wr_fire && wr_chan == CH_W'(i)),
      .wr_pos(wr_pos),
      .cnt(cnt),
      .pwm(pwm[i])
    );
  end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: frame-level model of the servo generator plus directed literal checks.
module tb_servo_pwm_multi;
  localparam int N = 4, PER = 1000, MINT = 50, STEP = 1, RPOS = 128;
`ifdef SERVO_PWM_SLEW_EN
  localparam int SLEW = 4;
`endif
  logic clk = 0, rst_n = 0, en = 0, wr_valid = 0;
  logic [1:0] wr_chan = 0;
  logic [7:0] wr_pos = 0;
  logic wr_ready, frame_start, running;
  logic [N-1:0] pwm;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .N_CH(N), .CH_W(2), .PERIOD_TICKS(PER), .MIN_TICKS(MINT), .STEP_TICKS(STEP),
    .CNT_W(10), .RESET_POS(RPOS), .SLEW_STEP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_chan(wr_chan), .wr_pos(wr_pos), .pwm(pwm), .frame_start(frame_start), .running(running)
  );

  // Model: frame phase, requested and applied positions, expected pulse outputs.
  bit m_run;
  int m_ph;
  int m_sh [N];
  int m_act [N];
  logic [N-1:0] m_pwm;
  logic exp_commit;
  assign exp_commit = m_run ? (m_ph == PER - 1) : en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 0;
      m_ph  <= 0;
      m_pwm <= '0;
      for (int i = 0; i < N; i++) begin
        m_sh[i]  <= RPOS;
        m_act[i] <= RPOS;
      end
    end else begin
      for (int i = 0; i < N; i++) m_pwm[i] <= m_run && (m_ph < MINT + m_act[i] * STEP);
      if (wr_valid && !exp_commit && int'(wr_chan) < N) m_sh[wr_chan] <= int'(wr_pos);
      if (exp_commit)
        for (int i = 0; i < N; i++)
`ifdef SERVO_PWM_SLEW_EN
          m_act[i] <= (m_sh[i] - m_act[i] > SLEW) ? m_act[i] + SLEW :
                      (m_act[i] - m_sh[i] > SLEW) ? m_act[i] - SLEW : m_sh[i];
`else
          m_act[i] <= m_sh[i];
`endif
      if (m_run) begin
        m_ph <= (m_ph == PER - 1) ? 0 : m_ph + 1;
        if (m_ph == PER - 1) m_run <= en;
      end else if (en) begin
        m_run <= 1;
        m_ph  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ({running, frame_start, wr_ready, pwm} !== {m_run, m_run && m_ph == 0, !exp_commit, m_pwm}) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t {run,fs,rdy,pwm} got %b required %b", $time,
                 {running, frame_start, wr_ready, pwm}, {m_run, m_run && m_ph == 0, !exp_commit, m_pwm});
      end
    end
  end

  // Measured pulse widths and frame period straight from the pins.
  int run_len [N];
  int last_w [N];
  int since = 0, last_period = 0;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (pwm[i]) run_len[i] <= run_len[i] + 1;
      else begin
        if (run_len[i] > 0) last_w[i] <= run_len[i];
        run_len[i] <= 0;
      end
    end
    if (frame_start) begin
      last_period <= since;
      since <= 1;
    end else since <= since + 1;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic at_phase(input int k);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(m_run && m_ph == k) && n < 3000);
    if (!(m_run && m_ph == k)) begin
      checks++;
      errors++;
      $display("FAIL at_phase_%0d timeout got run=%0d ph=%0d", k, m_run, m_ph);
    end
  endtask

  task automatic settle;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lows, n;
    logic [N-1:0] hi;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm", int'(pwm), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    rst_n = 1;
    @(posedge clk);
    #1;
    en = 1;
    at_phase(0);
    at_phase(0);
    settle;
    for (int i = 0; i < N; i++) chk($sformatf("reset_width_ch%0d", i), last_w[i], 178);
    chk("frame_period", last_period, 1000);

    at_phase(100);
    wr_valid = 1; wr_chan = 2; wr_pos = 255;
    @(posedge clk);
    #1;
    wr_valid = 0;
    at_phase(0);
    settle;
    chk("ch2_same_frame", last_w[2], 178);
    at_phase(0);
    settle;
    chk("ch2_next_frame", last_w[2], 305);
    chk("ch0_unchanged", last_w[0], 178);
    chk("ch3_unchanged", last_w[3], 178);

    at_phase(999);
    wr_valid = 1; wr_chan = 1; wr_pos = 10;
    lows = int'(!wr_ready);
    chk("hs_ready_at_wrap", int'(wr_ready), 0);
    @(posedge clk);
    #1;
    chk("hs_ready_after_wrap", int'(wr_ready), 1);
    lows += int'(!wr_ready);
    @(posedge clk);
    #1;
    wr_valid = 0;
    repeat (5) begin
      lows += int'(!wr_ready);
      @(posedge clk);
      #1;
    end
    chk("hs_ready_low_cycles", lows, 1);
    at_phase(0);
    settle;
    chk("hs_ch1_old_frame", last_w[1], 178);
    at_phase(0);
    settle;
    chk("hs_ch1_new_frame", last_w[1], 60);

    at_phase(100);
    en = 0;
    n = 0;
    while (m_run && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    settle;
    chk("en_off_running", int'(running), 0);
    chk("en_off_w0", last_w[0], 178);
    chk("en_off_w1", last_w[1], 60);
    chk("en_off_w2", last_w[2], 305);
    chk("en_off_w3", last_w[3], 178);
    hi = '0;
    repeat (20) begin
      @(negedge clk);
      hi |= pwm;
    end
    chk("idle_pwm_low", int'(hi), 0);
    @(posedge clk);
    #1;
    en = 1;
    @(posedge clk);
    #1;
    chk("reen_frame_start", int'(frame_start), 1);
    chk("reen_pwm_first", int'(pwm), 0);
    @(posedge clk);
    #1;
    chk("reen_pwm_second", int'(pwm), 4'hF);

    at_phase(60);
    chk("mid_pwm_high", int'(pwm), 4'hF);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_pwm", int'(pwm), 0);
    chk("async_rst_running", int'(running), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    at_phase(0);
    at_phase(0);
    settle;
    for (int i = 0; i < N; i++) chk($sformatf("post_rst_width_ch%0d", i), last_w[i], 178);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Parametrised N-channel hobby-servo PWM generator driven from the 50 MHz system clock.
- Each channel holds an 8-bit position written over a valid/ready port.
- All channels share one frame counter. Each channel outputs one pulse per frame, with width MIN_TICKS + pos*STEP_TICKS.
- New positions take effect only at frame boundaries, so no pulse is ever glitched.
- Replaces the fixed left/right two-position sequencer; sits between the control/UART logic and the servo pins.

Parameters:
- N_CH, 4, number of servo channels (1..16).
- CH_W, 2, channel-index width, equal to clog2(N_CH) with a minimum of 1.
- PERIOD_TICKS, 1000000, frame length in clocks (20 ms at 50 MHz).
- MIN_TICKS, 50000, pulse width at pos=0 (1 ms).
- STEP_TICKS, 195, extra clocks per position LSB; pos=255 gives 99725 clocks (~2 ms).
- CNT_W, 20, frame-counter width; must satisfy 2^CNT_W > PERIOD_TICKS.
- RESET_POS, 128, position loaded into all channels at reset.
- SLEW_STEP, 4, max position change per frame (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  level enable; generator runs while high
- wr_valid  in  1  position write request
- wr_ready  out  1  position write accepted when valid&ready
- wr_chan  in  CH_W  target channel
- wr_pos  in  8  new position 0..255
- pwm  out  N_CH  servo outputs, one bit per channel
- frame_start  out  1  one-cycle pulse at counter==0 while RUNNING
- running  out  1  high in state RUN

Behaviour:
- Reset (async assert, sync release):
  - State IDLE, counter=0.
  - All shadow and active positions = RESET_POS.
  - pwm=0, frame_start=0, running=0, wr_ready=1.
- FSM states:
  - IDLE: counter held at 0, pwm=0. en=1 → RUN next cycle with counter=0.
  - RUN: counter increments each clock and wraps PERIOD_TICKS-1 → 0. If en=0 is sampled at the wrap cycle, go to IDLE; otherwise stay in RUN.
  - en dropping mid-frame has no effect until the frame ends. The frame always completes, so no pulse is truncated.
- Pulse generation:
  - width[i] = MIN_TICKS + active_pos[i]*STEP_TICKS, computed in CNT_W bits.
  - Registered output: pwm[i] = 1 in the cycle after the counter value satisfies counter < width[i]. This is 1 cycle of fixed latency, and pulse length is exact.
  - Widths ≥ PERIOD_TICKS drive a constant high; implementation must assert this never occurs for legal params.
- Position write:
  - A write occurs on any cycle where wr_valid & wr_ready. wr_pos is stored to shadow[wr_chan].
  - wr_chan ≥ N_CH: the write is accepted and discarded.
  - Writes are accepted in IDLE and RUN.
- Commit:
  - Entering RUN from IDLE, and at every wrap in RUN, active_pos ← shadow for all channels in a single cycle.
  - wr_ready=0 only during that commit cycle, so a write never races the copy.
  - A write landing after the commit is applied at the next frame.
- frame_start is asserted in the same cycle counter==0 is first presented in RUN, including the first frame.
- Reset mid-frame: outputs drop to 0 immediately, asynchronously.

Optional Feature:
- Macro SERVO_PWM_SLEW_EN.
- Defined: at each commit, active_pos moves toward shadow by min(|shadow−active|, SLEW_STEP). Large commands ramp over several frames, with no overshoot.
- Undefined: active_pos ← shadow directly. SLEW_STEP is unused.

Decomposition:
- Package servo_pwm_pkg holds:
  - the state enum (IDLE, RUN);
  - 20 ms / 1 ms defaults as named constants;
  - the 8-bit position typedef;
  - a width function (pos → ticks).
- One sub-module, servo_pwm_chan:
  - holds the shadow/active register pair, the optional slew logic, and the compare against the shared counter;
  - is instantiated N_CH times by a generate loop.

Test Plan:
- Sim params PERIOD_TICKS=1000, MIN_TICKS=50, STEP_TICKS=1, N_CH=4.
- Reset check: after rst_n release with en=1, all pwm pulses are 178 clocks (50+128), and frame_start occurs every 1000 clocks.
- Position write: wr_chan=2, wr_pos=255 mid-frame → ch2 width unchanged this frame, 305 next frame; other channels stay at 178.
- Handshake: hold wr_valid across a wrap → wr_ready low exactly one cycle at commit; write lands in the following frame only.
- Enable: drop en at counter=100 → frame completes with full pulses, running falls after the wrap, and pwm stays 0. Re-raise en → first frame_start and pulse start 1 cycle later.
- Reset mid-frame: assert rst_n=0 at counter=60 during high pwm → pwm=0 without a clock edge, and positions return to 128.
- Slew (SERVO_PWM_SLEW_EN, SLEW_STEP=4): write 0→140 → widths 54, 58, … reach 190 in 35 frames, with no overshoot.
